hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Hazard and forwarding controller for the 16-bit five-stage pipeline. It shadows the destination-register record of the instructions in EX, MEM and WB. From that record it drives the ID-stage ForwardA/ForwardB operand selects and the stall, bubble and flush controls. A small state machine sequences load-use stalls and memory-wait freezes.

## Interface
Parameters:
- REG_W, 3, register-index width (8 architectural registers)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- Ra_ID  in  REG_W  source A index of the instruction in ID
- Rb_ID  in  REG_W  source B index of the instruction in ID
- useA_ID  in  1  ID instruction reads source A (ALU, compare or return address)
- useB_ID  in  1  ID instruction reads source B
- Rd_ID  in  REG_W  destination of the ID instruction
- regWrite_ID  in  1  ID instruction writes the register file
- memRead_ID  in  1  ID instruction is a load
- memOp_ID  in  1  ID instruction accesses data memory (load or store)
- branchTaken_ID  in  1  ID compare or jump resolved as redirect this cycle
- mem_ready  in  1  data memory completes the access in MEM this cycle
- ForwardA  out  2  00 regfile, 01 AluResult_EXE, 10 DataWB_MEM, 11 DataWB_WB
- ForwardB  out  2  same encoding
- stall  out  1  hold PC and the IF/ID register
- bubble  out  1  load NOP into ID/EX
- freeze  out  1  hold ID/EX, EX/MEM and MEM/WB, and suppress the WB write
- flush_IF  out  1  load NOP into IF/ID at the next edge
- WrEnable_WB  out  1  gated register-file write enable

## Operation
- Shadow record per stage (EX, MEM, WB): {valid, rd, regWrite, memRead, memOp}. Reset clears every valid bit.
- Advance rule:
  - freeze=1: all records hold.
  - Otherwise: WB<=MEM and MEM<=EX.
  - EX<=ID fields when bubble=0. EX<=invalid when bubble=1.
- A record matches source X when all hold: valid, regWrite, rd==X, and rd!=0 (R0 is never forwarded).
- Forward select for each source, highest priority first:
  - EX match and not memRead: 01.
  - MEM match: 10.
  - WB match: 11.
  - Otherwise: 00.
- A source with use=0 always selects 00.
- Load-use hazard: the EX record matches a used source and EX.memRead=1.
- States:
  - RUN: normal issue.
    - On a load-use hazard: stall=1 and bubble=1, go to LU_STALL.
    - If MEM.memOp=1 and mem_ready=0: go to MEM_WAIT. MEM_WAIT takes priority over the hazard.
  - LU_STALL: one cycle with stall=0. The load is now in MEM, so the dependent source gets 10. Go to RUN, or to MEM_WAIT if the MEM-wait condition holds.
  - MEM_WAIT: stall=1 and freeze=1 while mem_ready=0. When mem_ready=1, drop freeze that cycle and return to RUN.
- flush_IF = branchTaken_ID & ~stall & ~freeze. A taken branch that coincides with a stall is suppressed and re-resolved the next cycle.
- WrEnable_WB = WB.valid & WB.regWrite & ~freeze.

## Timing
- Reset values:
  - Outputs: ForwardA=00, ForwardB=00, stall=0, bubble=0, freeze=0, flush_IF=0, WrEnable_WB=0.
  - State: RUN.
- ForwardA, ForwardB, stall, bubble, flush_IF and WrEnable_WB are combinational from the records, the state and the current inputs. There is no registered latency.
- Records and state update on the rising clk edge.
- Load-use penalty is exactly 1 cycle. A back-to-back dependent load chain costs 1 cycle per link.
- MEM-wait penalty equals the number of cycles mem_ready stays low.
- Reset asserted mid-stall returns to RUN with invalid records on the same cycle, asynchronously.
- Simultaneous hazard on A and B from the same EX load is one stall, not two.
- When both EX and MEM match the same register, EX wins. This is the youngest-writer rule.

## Structure
- Shared package `pipe_pkg`:
  - FWD_REG, FWD_EXE, FWD_MEM, FWD_WB encodings.
  - State enum {RUN, LU_STALL, MEM_WAIT}.
  - dest_rec_t struct.
- Sub-module `dest_match`: combinational record-vs-source comparator plus the priority encoder to a forward select. Instantiated once per source.
- Records and the FSM stay in the top module.

## Test plan
- ALU dependency: write R3 in EX, ID reads Ra=3 -> ForwardA=01, stall=0. Next cycle the producer is in MEM -> ForwardA=10. The cycle after, in WB -> 11.
- Load-use: EX is a load to R5, ID reads Rb=5 -> stall=1, bubble=1 for 1 cycle. Next cycle ForwardB=10 and state returns to RUN.
- R0 write in EX with Ra=0 -> ForwardA=00.
- Double writer: EX and MEM both write R2 -> ForwardA=01.
- Memory wait: load in MEM with mem_ready low for 3 cycles -> stall=1, freeze=1 for 3 cycles, records unchanged, WrEnable_WB=0. On the 4th cycle freeze=0.
- Branch during load-use stall: branchTaken_ID=1 while stall=1 -> flush_IF=0. Next cycle branchTaken_ID=1 -> flush_IF=1.
- rst_n pulled low during MEM_WAIT -> all outputs at reset values immediately. After release, the first instruction sees ForwardA=ForwardB=00.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared encodings, FSM states and destination-record type for the pipeline hazard logic
package pipe_pkg;

  localparam int REC_W = 3;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hcu_state_t;

  typedef struct packed {
    logic             valid;
    logic [REC_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
    logic             mem_op;
  } dest_rec_t;

  function automatic logic rec_match(dest_rec_t rec, logic [REC_W-1:0] src);
    return rec.valid & rec.reg_write & (rec.rd == src) & (|src);
  endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// hazard_control_unit_if: ID-stage decode info in, forwarding and pipeline controls out
interface hazard_control_unit_if #(parameter int REG_W = 3);
  logic [REG_W-1:0] Ra_ID;
  logic [REG_W-1:0] Rb_ID;
  logic             useA_ID;
  logic             useB_ID;
  logic [REG_W-1:0] Rd_ID;
  logic             regWrite_ID;
  logic             memRead_ID;
  logic             memOp_ID;
  logic             branchTaken_ID;
  logic             mem_ready;
  logic [1:0]       ForwardA;
  logic [1:0]       ForwardB;
  logic             stall;
  logic             bubble;
  logic             freeze;
  logic             flush_IF;
  logic             WrEnable_WB;
  modport master (
    output Ra_ID, Rb_ID, useA_ID, useB_ID, Rd_ID, regWrite_ID, memRead_ID, memOp_ID,
           branchTaken_ID, mem_ready,
    input  ForwardA, ForwardB, stall, bubble, freeze, flush_IF, WrEnable_WB
  );
  modport slave (
    input  Ra_ID, Rb_ID, useA_ID, useB_ID, Rd_ID, regWrite_ID, memRead_ID, memOp_ID,
           branchTaken_ID, mem_ready,
    output ForwardA, ForwardB, stall, bubble, freeze, flush_IF, WrEnable_WB
  );
endinterface

// File: rtl/dest_match.sv
// dest_match: compares one ID source against the EX/MEM/WB records and picks the youngest forward
module dest_match
  import pipe_pkg::*;
(
  input  dest_rec_t        i_ex,
  input  dest_rec_t        i_mem,
  input  dest_rec_t        i_wb,
  input  logic [REC_W-1:0] i_src,
  input  logic             i_use,
  output logic [1:0]       o_fwd,
  output logic             o_lu
);
  logic w_ex_hit;
  logic w_mem_hit;
  logic w_wb_hit;
  logic w_unused;
  assign w_unused = ^{i_ex.mem_op, i_mem.mem_read, i_mem.mem_op, i_wb.mem_read, i_wb.mem_op};
  // youngest matching writer wins; a load still in EX cannot supply data yet
  always_comb begin
    w_ex_hit  = i_use & rec_match(i_ex, i_src);
    w_mem_hit = i_use & rec_match(i_mem, i_src);
    w_wb_hit  = i_use & rec_match(i_wb, i_src);
    o_lu      = w_ex_hit & i_ex.mem_read;
    o_fwd     = (w_ex_hit & ~i_ex.mem_read) ? FWD_EXE :
                w_mem_hit                   ? FWD_MEM :
                w_wb_hit                    ? FWD_WB  : FWD_REG;
  end
endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: shadows EX/MEM/WB destinations, drives forwarding and stall/bubble/freeze/flush
module hazard_control_unit
  import pipe_pkg::*;
#(
  parameter int REG_W = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  hazard_control_unit_if.slave bus
);
  if (REG_W != REC_W) begin : g_width_check
    $error("REG_W must equal pipe_pkg::REC_W");
  end
  dest_rec_t  r_ex;
  dest_rec_t  r_mem;
  dest_rec_t  r_wb;
  dest_rec_t  w_id;
  hcu_state_t r_state;
  hcu_state_t w_next;
  logic       w_lu_a;
  logic       w_lu_b;
  logic       w_hazard;
  logic       w_mem_wait;
  logic       w_bubble;
  assign w_id = '{valid: 1'b1, rd: bus.Rd_ID, reg_write: bus.regWrite_ID,
                  mem_read: bus.memRead_ID, mem_op: bus.memOp_ID};
  dest_match u_match_a (
    .i_ex(r_ex), .i_mem(r_mem), .i_wb(r_wb),
    .i_src(bus.Ra_ID), .i_use(bus.useA_ID),
    .o_fwd(bus.ForwardA), .o_lu(w_lu_a)
  );
  dest_match u_match_b (
    .i_ex(r_ex), .i_mem(r_mem), .i_wb(r_wb),
    .i_src(bus.Rb_ID), .i_use(bus.useB_ID),
    .o_fwd(bus.ForwardB), .o_lu(w_lu_b)
  );
  // memory wait freezes the back end and outranks a load-use bubble; one bubble covers both sources
  always_comb begin
    w_mem_wait = r_mem.valid & r_mem.mem_op & ~bus.mem_ready;
    w_hazard   = (w_lu_a | w_lu_b) & (r_state != LU_STALL);
    w_bubble   = w_hazard & ~w_mem_wait;
    w_next     = w_mem_wait ? MEM_WAIT : w_bubble ? LU_STALL : RUN;
  end
  assign bus.stall       = w_mem_wait | w_hazard;
  assign bus.bubble      = w_bubble;
  assign bus.freeze      = w_mem_wait;
  assign bus.flush_IF    = bus.branchTaken_ID & ~bus.stall & ~w_mem_wait;
  assign bus.WrEnable_WB = r_wb.valid & r_wb.reg_write & ~w_mem_wait;
  // sequencer state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_next;
  end
  // destination records shift forward unless frozen; a bubble enters EX as an invalid record
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (!w_mem_wait) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_bubble ? '0 : w_id;
    end
  end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed pipeline scenarios with a queue of expected control vectors
module tb_hazard_control_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  logic [8:0] sb[$];
  hazard_control_unit_if #(.REG_W(3)) bus ();
  hazard_control_unit #(.REG_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic sample(input string tag);
    logic [8:0] e;
    e = (sb.size() != 0) ? sb.pop_front() : 9'h1ff;
    check(tag, {bus.ForwardA, bus.ForwardB, bus.stall, bus.bubble, bus.freeze, bus.flush_IF,
                bus.WrEnable_WB}, e);
  endtask
  task automatic drive(input logic [2:0] ra, input logic ua, input logic [2:0] rb, input logic ub,
                       input logic [2:0] rd, input logic rw, input logic mr, input logic mo,
                       input logic br, input logic rdy);
    bus.Ra_ID = ra;
    bus.useA_ID = ua;
    bus.Rb_ID = rb;
    bus.useB_ID = ub;
    bus.Rd_ID = rd;
    bus.regWrite_ID = rw;
    bus.memRead_ID = mr;
    bus.memOp_ID = mo;
    bus.branchTaken_ID = br;
    bus.mem_ready = rdy;
  endtask
  // expected vector is {ForwardA, ForwardB, stall, bubble, freeze, flush_IF, WrEnable_WB}
  task automatic step(input string tag, input logic [2:0] ra, input logic ua, input logic [2:0] rb,
                      input logic ub, input logic [2:0] rd, input logic rw, input logic mr,
                      input logic mo, input logic br, input logic rdy, input logic [8:0] e);
    @(posedge clk);
    #1;
    drive(ra, ua, rb, ub, rd, rw, mr, mo, br, rdy);
    sb.push_back(e);
    @(negedge clk);
    sample(tag);
  endtask
  initial begin
    drive(3, 1, 5, 1, 0, 0, 0, 0, 1, 1);
    sb.push_back(9'b00_00_0_0_0_0_0);
    #1;
    bus.branchTaken_ID = 1'b0;
    #2;
    sample("reset");
    #9 rst_n = 1'b1;
    step("alu_prod",    0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 9'b00_00_0_0_0_0_0);
    step("alu_ex",      3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 9'b01_00_0_0_0_0_0);
    step("alu_mem_noa", 3, 0, 3, 1, 0, 0, 0, 0, 0, 1, 9'b00_10_0_0_0_0_0);
    step("alu_wb",      3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 9'b11_00_0_0_0_0_1);
    step("nop",         0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9'b00_00_0_0_0_0_0);
    step("ld5_issue",   0, 0, 0, 0, 5, 1, 1, 1, 0, 1, 9'b00_00_0_0_0_0_0);
    step("lu_stall_br", 0, 0, 5, 1, 0, 0, 0, 0, 1, 1, 9'b00_00_1_1_0_0_0);
    step("lu_fwd_br",   0, 0, 5, 1, 0, 0, 0, 0, 1, 1, 9'b00_10_0_0_0_1_0);
    step("lu_wb",       5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 9'b11_00_0_0_0_0_1);
    step("r0_prod",     0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 9'b00_00_0_0_0_0_0);
    step("r0_fwd",      0, 1, 0, 0, 2, 1, 0, 0, 0, 1, 9'b00_00_0_0_0_0_0);
    step("r2_prod2",    0, 0, 0, 0, 2, 1, 0, 0, 0, 1, 9'b00_00_0_0_0_0_0);
    step("youngest",    2, 1, 2, 1, 0, 0, 0, 0, 0, 1, 9'b01_01_0_0_0_0_1);
    step("ld4_issue",   0, 0, 0, 0, 4, 1, 1, 1, 0, 1, 9'b00_00_0_0_0_0_1);
    step("lu_ab",       4, 1, 4, 1, 0, 0, 0, 0, 0, 1, 9'b00_00_1_1_0_0_1);
    step("lu_ab_fwd",   4, 1, 4, 1, 0, 0, 0, 0, 0, 1, 9'b10_10_0_0_0_0_0);
    step("r1_prod",     0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 9'b00_00_0_0_0_0_1);
    step("ld6_issue",   0, 0, 0, 0, 6, 1, 1, 1, 0, 1, 9'b00_00_0_0_0_0_0);
    step("r7_prod",     0, 0, 0, 0, 7, 1, 0, 0, 0, 1, 9'b00_00_0_0_0_0_0);
    for (int i = 0; i < 3; i++)
      step("mem_wait",  7, 1, 1, 1, 0, 0, 0, 0, 1, 0, 9'b01_11_1_0_1_0_0);
    step("mem_done",    7, 1, 1, 1, 0, 0, 0, 0, 1, 1, 9'b01_11_0_0_0_1_1);
    step("ld3_issue",   0, 0, 0, 0, 3, 1, 1, 1, 0, 1, 9'b00_00_0_0_0_0_1);
    step("pre_wait",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9'b00_00_0_0_0_0_1);
    step("wait_rst",    3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 9'b10_00_1_0_1_0_0);
    #2;
    rst_n = 1'b0;
    sb.push_back(9'b00_00_0_0_0_0_0);
    #1;
    sample("rst_async");
    @(posedge clk);
    #1;
    sb.push_back(9'b00_00_0_0_0_0_0);
    sample("rst_hold");
    #3 rst_n = 1'b1;
    step("post_rst",    3, 1, 6, 1, 0, 0, 0, 0, 0, 1, 9'b00_00_0_0_0_0_0);
    step("post_rst2",   3, 1, 6, 1, 0, 0, 0, 0, 0, 1, 9'b00_00_0_0_0_0_0);
    check("sb_drain", 9'(sb.size()), 9'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
